// File: rtl/dmi_pkg.sv
// DMI widths, op codes and arbiter state encoding
// shared by the DMI request arbiter slice.
package dmi_pkg;

  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;
  localparam int DMI_OP_WIDTH   = 2;
  localparam int TX_WIDTH =
    DMI_ADDR_WIDTH + DMI_DATA_WIDTH + DMI_OP_WIDTH;
  localparam int RX_WIDTH =
    DMI_DATA_WIDTH + DMI_OP_WIDTH;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RET
  } arb_state_e;

  function automatic logic [RX_WIDTH-1:0] dmi_fail_resp();
    return {{DMI_DATA_WIDTH{1'b0}}, DMI_RESP_FAILED};
  endfunction

endpackage

// File: rtl/dmi_req_arbiter_if.sv
// Requester, target and response handshakes of the
// DMI arbiter; slave = arbiter view, master = environment.
interface dmi_req_arbiter_if;
  import dmi_pkg::*;

  logic                m0_req_vld;
  logic [TX_WIDTH-1:0] m0_req_data;
  logic                m0_req_rdy;
  logic                m0_resp_vld;
  logic [RX_WIDTH-1:0] m0_resp_data;
  logic                m0_resp_rdy;

  logic                m1_req_vld;
  logic [TX_WIDTH-1:0] m1_req_data;
  logic                m1_req_rdy;
  logic                m1_resp_vld;
  logic [RX_WIDTH-1:0] m1_resp_data;
  logic                m1_resp_rdy;

  logic                creq_vld;
  logic [TX_WIDTH-1:0] creq_data;
  logic                creq_rdy;
  logic                cresp_vld;
  logic [RX_WIDTH-1:0] cresp_data;
  logic                cresp_rdy;

  modport slave (
    input  m0_req_vld, m0_req_data, m0_resp_rdy,
    output m0_req_rdy, m0_resp_vld, m0_resp_data,
    input  m1_req_vld, m1_req_data, m1_resp_rdy,
    output m1_req_rdy, m1_resp_vld, m1_resp_data,
    output creq_vld, creq_data, cresp_rdy,
    input  creq_rdy, cresp_vld, cresp_data
  );

  modport master (
    output m0_req_vld, m0_req_data, m0_resp_rdy,
    input  m0_req_rdy, m0_resp_vld, m0_resp_data,
    output m1_req_vld, m1_req_data, m1_resp_rdy,
    input  m1_req_rdy, m1_resp_vld, m1_resp_data,
    input  creq_vld, creq_data, cresp_rdy,
    output creq_rdy, cresp_vld, cresp_data
  );

endinterface

// File: rtl/dmi_rr_pick.sv
// Two-way round-robin pick: a lone requester always
// wins; on a tie the one not granted last wins.
module dmi_rr_pick (
  input  logic [1:0] vld,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot (or zero) grant from valids and pointer
  always_comb begin
    grant = 2'b00;
    unique case (vld)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmi_req_arbiter.sv
// Shares one DMI target port between two requesters.
// Optional response timeout: DMI_ARB_TIMEOUT_EN.
module dmi_req_arbiter
  import dmi_pkg::*;
`ifdef DMI_ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
  input logic         clock,
  input logic         reset,
  dmi_req_arbiter_if.slave bus
);

  arb_state_e          state;
  logic [TX_WIDTH-1:0] req_q;
  logic [RX_WIDTH-1:0] resp0_q;
  logic [RX_WIDTH-1:0] resp1_q;
  logic [RX_WIDTH-1:0] rsp_in;
  logic [1:0]          resp_vld_q;
  logic [1:0]          grant;
  logic                gid;
  logic                last_grant;
  logic                creq_vld_q;
  logic                cresp_rdy_q;
  logic                accept;
  logic                resp_take;
  logic                to_hit;

  dmi_rr_pick u_pick (
    .vld        ({bus.m1_req_vld, bus.m0_req_vld}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept = (state == ARB_IDLE) && (|grant);

  assign bus.m0_req_rdy = (state == ARB_IDLE) && grant[0];
  assign bus.m1_req_rdy = (state == ARB_IDLE) && grant[1];

  assign bus.creq_vld  = creq_vld_q;
  assign bus.creq_data = req_q;
  assign bus.cresp_rdy = cresp_rdy_q;

  assign bus.m0_resp_vld  = resp_vld_q[0];
  assign bus.m1_resp_vld  = resp_vld_q[1];
  assign bus.m0_resp_data = resp0_q;
  assign bus.m1_resp_data = resp1_q;

  assign resp_take = gid ? bus.m1_resp_rdy : bus.m0_resp_rdy;

  assign rsp_in = bus.cresp_vld ? bus.cresp_data
                                : dmi_fail_resp();

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;

  // Counts WAIT cycles; zero whenever not waiting
  always_ff @(posedge clock) begin
    if (reset || state != ARB_WAIT) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (state == ARB_WAIT) && (to_cnt == CNT_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // Transaction sequencer: accept, forward, collect, return
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB_IDLE;
      last_grant  <= 1'b1;
      gid         <= 1'b0;
      req_q       <= '0;
      resp0_q     <= '0;
      resp1_q     <= '0;
      resp_vld_q  <= 2'b00;
      creq_vld_q  <= 1'b0;
      cresp_rdy_q <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (accept) begin
            req_q <= grant[1] ? bus.m1_req_data
                              : bus.m0_req_data;
            gid        <= grant[1];
            creq_vld_q <= 1'b1;
            state      <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (bus.creq_rdy) begin
            creq_vld_q  <= 1'b0;
            cresp_rdy_q <= 1'b1;
            state       <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.cresp_vld || to_hit) begin
            cresp_rdy_q <= 1'b0;
            if (gid) begin
              resp1_q <= rsp_in;
            end else begin
              resp0_q <= rsp_in;
            end
            resp_vld_q <= gid ? 2'b10 : 2'b01;
            state      <= ARB_RET;
          end
        end
        ARB_RET: begin
          if (resp_take) begin
            resp_vld_q <= 2'b00;
            last_grant <= gid;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Randomized scoreboard bench for dmi_req_arbiter
// against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_dmi_req_arbiter;
  import dmi_pkg::*;

  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dmi_req_arbiter_if bus ();

`ifdef DMI_ARB_TIMEOUT_EN
  dmi_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`else
  dmi_req_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`endif

  always #5 clock = ~clock;

  typedef struct {
    bit                  id;
    logic [RX_WIDTH-1:0] d;
  } resp_t;

  int n_chk = 0;
  int n_fail = 0;
  int n_to = 0;

  logic [TX_WIDTH-1:0] rq0[$];
  logic [TX_WIDTH-1:0] rq1[$];
  logic [TX_WIDTH-1:0] exp_creq[$];
  resp_t               exp_resp[$];

  // model: phase 0 free, 1 to target, 2 at target, 3 back
  int  m_phase = 0;
  bit  m_id = 0;
  bit  m_last = 1;
  int  m_waited = 0;
  bit  post_rst = 0;

  bit  acc0 = 0, acc1 = 0;
  bit  en0 = 1, en1 = 1;
  int  rst_cycles = 2;
  int  creq_hold = 0;
  int  resp_hold = 0;
  bit  t_armed = 0;
  bit  t_mute = 0;
  int  t_delay = 0;
  logic [RX_WIDTH-1:0] t_data = '0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic expire(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  function automatic logic [TX_WIDTH-1:0] rand_req();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[TX_WIDTH-1:0];
  endfunction

  function automatic logic [RX_WIDTH-1:0] rand_rsp();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[RX_WIDTH-1:0];
  endfunction

  // Driver: requesters, target and reset, just after posedge
  initial begin
    bus.m0_req_vld = 0; bus.m0_req_data = '0;
    bus.m1_req_vld = 0; bus.m1_req_data = '0;
    bus.m0_resp_rdy = 0; bus.m1_resp_rdy = 0;
    bus.creq_rdy = 0; bus.cresp_vld = 0;
    bus.cresp_data = '0;
    forever begin
      @(posedge clock);
      #1;
      if (rst_cycles > 0) begin
        reset = 1;
        rst_cycles--;
        bus.m0_req_vld = 0;
        bus.m1_req_vld = 0;
        bus.creq_rdy = 0;
        bus.cresp_vld = 0;
        bus.m0_resp_rdy = 0;
        bus.m1_resp_rdy = 0;
      end else begin
        reset = 0;
        if (!(bus.m0_req_vld && !acc0)) begin
          acc0 = 0;
          if (en0 && rq0.size() > 0 &&
              $urandom_range(0, 3) != 0) begin
            bus.m0_req_vld = 1;
            bus.m0_req_data = rq0[0];
          end else begin
            bus.m0_req_vld = 0;
          end
        end
        if (!(bus.m1_req_vld && !acc1)) begin
          acc1 = 0;
          if (en1 && rq1.size() > 0 &&
              $urandom_range(0, 3) != 0) begin
            bus.m1_req_vld = 1;
            bus.m1_req_data = rq1[0];
          end else begin
            bus.m1_req_vld = 0;
          end
        end
        if (creq_hold > 0) begin
          creq_hold--;
          bus.creq_rdy = 0;
        end else begin
          bus.creq_rdy = ($urandom_range(0, 3) != 0);
        end
        if (resp_hold > 0) begin
          resp_hold--;
          bus.m0_resp_rdy = 0;
          bus.m1_resp_rdy = 0;
        end else begin
          bus.m0_resp_rdy = ($urandom_range(0, 2) != 0);
          bus.m1_resp_rdy = ($urandom_range(0, 2) != 0);
        end
        if (t_armed && !t_mute) begin
          if (!bus.cresp_vld) begin
            if (t_delay > 0) begin
              t_delay--;
            end else begin
              bus.cresp_vld = 1;
              bus.cresp_data = t_data;
            end
          end
        end else if (t_armed) begin
          bus.cresp_vld = 0;
        end else begin
          bus.cresp_vld = ($urandom_range(0, 5) == 0);
          bus.cresp_data = rand_rsp();
        end
      end
    end
  end

  // Monitor + reference model, on the falling edge
  initial begin
    bit e_rdy0, e_rdy1;
    resp_t r;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_phase = 0;
        m_last = 1;
        exp_creq.delete();
        exp_resp.delete();
        t_armed = 0;
        post_rst = 1;
        acc0 = 0;
        acc1 = 0;
      end else begin
        if (post_rst) begin
          post_rst = 0;
          check("rst_creq_data", 64'(bus.creq_data), 0);
          check("rst_m0_resp_data", 64'(bus.m0_resp_data), 0);
          check("rst_m1_resp_data", 64'(bus.m1_resp_data), 0);
        end
        e_rdy0 = (m_phase == 0) && bus.m0_req_vld &&
                 (!bus.m1_req_vld || m_last);
        e_rdy1 = (m_phase == 0) && bus.m1_req_vld &&
                 (!bus.m0_req_vld || !m_last);
        check("m0_req_rdy", 64'(bus.m0_req_rdy), 64'(e_rdy0));
        check("m1_req_rdy", 64'(bus.m1_req_rdy), 64'(e_rdy1));
        check("creq_vld", 64'(bus.creq_vld),
              64'(m_phase == 1));
        check("cresp_rdy", 64'(bus.cresp_rdy),
              64'(m_phase == 2));
        check("m0_resp_vld", 64'(bus.m0_resp_vld),
              64'(m_phase == 3 && m_id == 0));
        check("m1_resp_vld", 64'(bus.m1_resp_vld),
              64'(m_phase == 3 && m_id == 1));
        case (m_phase)
          0: begin
            if (e_rdy0) begin
              exp_creq.push_back(bus.m0_req_data);
              void'(rq0.pop_front());
              acc0 = 1;
              m_id = 0;
              m_phase = 1;
            end else if (e_rdy1) begin
              exp_creq.push_back(bus.m1_req_data);
              void'(rq1.pop_front());
              acc1 = 1;
              m_id = 1;
              m_phase = 1;
            end
          end
          1: begin
            if (bus.creq_rdy) begin
              if (exp_creq.size() == 0) begin
                check("creq_queue", 1, 0);
              end else begin
                check("creq_data", 64'(bus.creq_data),
                      64'(exp_creq.pop_front()));
              end
              m_phase = 2;
              m_waited = 0;
              t_armed = 1;
              t_delay = $urandom_range(0, 4);
              t_data = rand_rsp();
            end
          end
          2: begin
            if (bus.cresp_vld) begin
              r.id = m_id;
              r.d = bus.cresp_data;
              exp_resp.push_back(r);
              m_phase = 3;
              t_armed = 0;
            end else begin
              m_waited++;
`ifdef DMI_ARB_TIMEOUT_EN
              if (m_waited == TO) begin
                r.id = m_id;
                r.d = {32'h0, 2'b10};
                exp_resp.push_back(r);
                m_phase = 3;
                t_armed = 0;
                n_to++;
              end
`endif
            end
          end
          default: begin
            if (m_id ? bus.m1_resp_rdy : bus.m0_resp_rdy) begin
              if (exp_resp.size() == 0) begin
                check("resp_queue", 1, 0);
              end else begin
                r = exp_resp.pop_front();
                check(r.id ? "m1_resp_data" : "m0_resp_data",
                      64'(r.id ? bus.m1_resp_data
                               : bus.m0_resp_data),
                      64'(r.d));
              end
              m_last = m_id;
              m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Scenario sequencing
  initial begin
    int bound;
    int to0;
    rq0.push_back({7'h11, 32'h0, DMI_OP_READ});
    repeat (4) @(posedge clock);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock);
      if (rq0.size() < 3) rq0.push_back(rand_req());
      if (rq1.size() < 3) rq1.push_back(rand_req());
      en0 = !(c >= 1300 && c < 1600);
      en1 = !(c >= 1000 && c < 1300);
      if ($urandom_range(0, 99) == 0) creq_hold = 5;
      if ($urandom_range(0, 99) == 1) resp_hold = 4;
      if (c >= 2000 && c % 500 == 0) begin
        t_mute = 1;
        bound = 0;
        while (m_phase != 2 && bound < 200) begin
          @(posedge clock);
          bound++;
        end
        if (bound >= 200) expire("reach_wait");
        rst_cycles = 1;
        repeat (3) @(posedge clock);
        t_mute = 0;
      end
`ifdef DMI_ARB_TIMEOUT_EN
      if (c == 3700) begin
        to0 = n_to;
        t_mute = 1;
        bound = 0;
        while (n_to == to0 && bound < 300) begin
          @(posedge clock);
          bound++;
        end
        if (bound >= 300) expire("timeout_resp");
        t_mute = 0;
      end
`endif
    end
    en0 = 0;
    en1 = 0;
    bound = 0;
    while ((m_phase != 0 || bus.m0_req_vld || bus.m1_req_vld)
           && bound < 500) begin
      @(posedge clock);
      bound++;
    end
    if (bound >= 500) expire("drain");
    repeat (4) @(posedge clock);
    check("creq_left", 64'(exp_creq.size()), 0);
    check("resp_left", 64'(exp_resp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
